mem_stage: RTL and testbench

Memory stage of the Dioptase pipeline, directly downstream of the execute stage.
- Captures the instruction leaving execute and collects the read data for loads.
- Extracts and zero-extends word, doubleword and byte loads from the returned 32-bit word.
- Holds the pipeline while memory is not ready, and raises a bus-error exception on timeout.
- Drives the MEM-side forwarding and hazard signals that execute consumes, and the registered WB-side bundle.

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: holds the instruction leaving execute, waits on load data,
// extracts sub-word loads and hands the completed instruction to writeback.
module mem_stage #(
  parameter int         TIMEOUT = 16,
  parameter logic [7:0] BUS_EXC = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        bubble_in,
  input  logic [4:0]  opcode_in,
  input  logic [4:0]  tgt_in_1,
  input  logic [4:0]  tgt_in_2,
  input  logic [31:0] result_in_1,
  input  logic [31:0] result_in_2,
  input  logic [31:0] addr_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        tgts_cr_in,
  input  logic [7:0]  exc_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        exc_in_wb,
  input  logic        rfe_in_wb,
  output logic [4:0]  mem_tgt_1,
  output logic [4:0]  mem_tgt_2,
  output logic [31:0] mem_result_out_1,
  output logic [31:0] mem_result_out_2,
  output logic        mem_bubble,
  output logic        is_load_mem,
  output logic        mem_tgts_cr,
  output logic [4:0]  mem_opcode_out,
  output logic        mem_stall,
  output logic [4:0]  wb_tgt_1,
  output logic [4:0]  wb_tgt_2,
  output logic [31:0] wb_result_out_1,
  output logic [31:0] wb_result_out_2,
  output logic        wb_bubble,
  output logic        wb_tgts_cr,
  output logic [7:0]  wb_exc,
  output logic [31:0] wb_pc
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {RUN, WAIT} state_t;

  typedef struct packed {
    logic        bubble;
    logic [4:0]  opcode;
    logic [4:0]  tgt_1;
    logic [4:0]  tgt_2;
    logic [31:0] result_1;
    logic [31:0] result_2;
    logic [1:0]  addr;
    logic        is_load;
    logic        tgts_cr;
    logic [7:0]  exc;
    logic [31:0] pc;
  } mem_instr_t;

  function automatic mem_instr_t bubble_instr();
    bubble_instr        = '0;
    bubble_instr.bubble = 1'b1;
  endfunction

  state_t          state, state_nxt;
  logic [7:0]      wait_cnt;
  mem_instr_t      mem_q, ex_d;
  logic            flush, valid_load, timeout_hit;
  logic [31:0]     load_data;
  logic [3:0][7:0] rd_bytes;
  logic            unused_bits;

  // Only the byte offset matters; stores need nothing from this stage.
  assign unused_bits = ^{addr_in[31:2], is_store_in};

  always_comb begin
    ex_d          = '0;
    ex_d.bubble   = bubble_in;
    ex_d.opcode   = opcode_in;
    ex_d.tgt_1    = tgt_in_1;
    ex_d.tgt_2    = tgt_in_2;
    ex_d.result_1 = result_in_1;
    ex_d.result_2 = result_in_2;
    ex_d.addr     = addr_in[1:0];
    ex_d.is_load  = is_load_in;
    ex_d.tgts_cr  = tgts_cr_in;
    ex_d.exc      = exc_in;
    ex_d.pc       = pc_in;
  end

  assign mem_tgt_1        = mem_q.tgt_1;
  assign mem_tgt_2        = mem_q.tgt_2;
  assign mem_result_out_1 = mem_q.result_1;
  assign mem_result_out_2 = mem_q.result_2;
  assign mem_bubble       = mem_q.bubble;
  assign is_load_mem      = mem_q.is_load;
  assign mem_tgts_cr      = mem_q.tgts_cr;
  assign mem_opcode_out   = mem_q.opcode;

  // Zero-extended sub-word extraction from the little-endian word.
  assign rd_bytes = mem_rdata;
  always_comb begin
    load_data = mem_rdata;
    if (mem_q.opcode inside {[5'd6:5'd8]})
      load_data = {16'h0, mem_q.addr[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
    else if (mem_q.opcode inside {[5'd9:5'd11]})
      load_data = {24'h0, rd_bytes[mem_q.addr]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else if (clk_en)
      state <= halt ? RUN : state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = RUN;
    else begin
      case (state)
        RUN:     if (valid_load && !mem_ready) state_nxt = WAIT;
        WAIT:    if (mem_ready || timeout_hit) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    flush       = exc_in_wb || rfe_in_wb;
    valid_load  = mem_q.is_load && !mem_q.bubble && (mem_q.exc == 8'h00);
    timeout_hit = (state == WAIT) && (wait_cnt == TMO_LAST) && !mem_ready;
    mem_stall   = valid_load && !mem_ready && !flush && !timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst || (clk_en && halt)) begin
      wait_cnt        <= '0;
      mem_q           <= bubble_instr();
      wb_tgt_1        <= '0;
      wb_tgt_2        <= '0;
      wb_result_out_1 <= '0;
      wb_result_out_2 <= '0;
      wb_bubble       <= 1'b1;
      wb_tgts_cr      <= 1'b0;
      wb_exc          <= '0;
      wb_pc           <= rst ? '0 : pc_in;
    end else if (clk_en) begin
      wait_cnt <= (state == WAIT && mem_stall) ? wait_cnt + 8'd1 : '0;
      if (flush || mem_stall) begin
        // WB sees a bubble; MEM holds on stall, empties on flush.
        wb_tgt_1        <= '0;
        wb_tgt_2        <= '0;
        wb_result_out_1 <= '0;
        wb_result_out_2 <= '0;
        wb_bubble       <= 1'b1;
        wb_tgts_cr      <= 1'b0;
        wb_exc          <= '0;
        if (flush) mem_q <= bubble_instr();
      end else begin
        mem_q           <= ex_d;
        wb_bubble       <= mem_q.bubble;
        wb_tgts_cr      <= mem_q.tgts_cr;
        wb_pc           <= mem_q.pc;
        wb_result_out_2 <= mem_q.result_2;
        if (timeout_hit) begin
          wb_tgt_1        <= '0;
          wb_tgt_2        <= '0;
          wb_result_out_1 <= '0;
          wb_exc          <= BUS_EXC;
        end else begin
          wb_tgt_1        <= mem_q.tgt_1;
          wb_tgt_2        <= mem_q.tgt_2;
          wb_result_out_1 <= mem_q.is_load ? load_data : mem_q.result_1;
          wb_exc          <= mem_q.exc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage against a cycle-count model
// of loads, stalls, timeouts, flushes and reset.
module tb_mem_stage;
  localparam int         TMO = 4;
  localparam logic [7:0] BEXC = 8'h2C;

  logic        clk = 1'b0;
  logic        rst, clk_en, halt, bubble_in, is_load_in, is_store_in, tgts_cr_in;
  logic [4:0]  opcode_in, tgt_in_1, tgt_in_2;
  logic [31:0] result_in_1, result_in_2, addr_in, pc_in, mem_rdata;
  logic [7:0]  exc_in;
  logic        mem_ready, exc_in_wb, rfe_in_wb;
  logic [4:0]  mem_tgt_1, mem_tgt_2, mem_opcode_out, wb_tgt_1, wb_tgt_2;
  logic [31:0] mem_result_out_1, mem_result_out_2, wb_result_out_1, wb_result_out_2, wb_pc;
  logic        mem_bubble, is_load_mem, mem_tgts_cr, mem_stall, wb_bubble, wb_tgts_cr;
  logic [7:0]  wb_exc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        bubble;
    logic [4:0]  opcode, tgt1, tgt2;
    logic [31:0] r1, r2, addr, pc;
    logic        ld, st, cr;
    logic [7:0]  exc;
  } instr_t;

  mem_stage #(.TIMEOUT(TMO), .BUS_EXC(BEXC)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .bubble_in(bubble_in),
    .opcode_in(opcode_in), .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2),
    .result_in_1(result_in_1), .result_in_2(result_in_2), .addr_in(addr_in),
    .is_load_in(is_load_in), .is_store_in(is_store_in), .tgts_cr_in(tgts_cr_in),
    .exc_in(exc_in), .pc_in(pc_in), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .exc_in_wb(exc_in_wb), .rfe_in_wb(rfe_in_wb),
    .mem_tgt_1(mem_tgt_1), .mem_tgt_2(mem_tgt_2),
    .mem_result_out_1(mem_result_out_1), .mem_result_out_2(mem_result_out_2),
    .mem_bubble(mem_bubble), .is_load_mem(is_load_mem), .mem_tgts_cr(mem_tgts_cr),
    .mem_opcode_out(mem_opcode_out), .mem_stall(mem_stall),
    .wb_tgt_1(wb_tgt_1), .wb_tgt_2(wb_tgt_2),
    .wb_result_out_1(wb_result_out_1), .wb_result_out_2(wb_result_out_2),
    .wb_bubble(wb_bubble), .wb_tgts_cr(wb_tgts_cr), .wb_exc(wb_exc), .wb_pc(wb_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] extract(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] d);
    if (op >= 9 && op <= 11) return (d >> (8 * int'(a[1:0]))) & 32'hFF;
    if (op >= 6 && op <= 8)  return (d >> (16 * int'(a[1]))) & 32'hFFFF;
    return d;
  endfunction

  function automatic instr_t nop_i();
    instr_t x;
    x = '{bubble: 1'b1, default: '0};
    return x;
  endfunction

  function automatic instr_t alu(input logic [4:0] t, input logic [31:0] r);
    instr_t x;
    x = '{default: '0};
    x.opcode = 5'd1; x.tgt1 = t; x.tgt2 = t ^ 5'h1F; x.r1 = r; x.r2 = r ^ 32'h55;
    x.pc = r + 32'd4;
    return x;
  endfunction

  function automatic instr_t ld(input logic [4:0] op, input logic [31:0] a, input logic [4:0] t);
    instr_t x;
    x = '{default: '0};
    x.ld = 1'b1; x.opcode = op; x.addr = a; x.tgt1 = t; x.tgt2 = t + 5'd1;
    x.r1 = 32'hF00D_0000 | a; x.r2 = a + 32'd4; x.pc = a ^ 32'h4000;
    return x;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t x;
    x = '{default: '0};
    x.bubble = ($urandom_range(7) == 0);
    x.tgt1 = 5'($urandom); x.tgt2 = 5'($urandom);
    x.r1 = $urandom; x.r2 = $urandom; x.addr = $urandom; x.pc = $urandom;
    x.cr = 1'($urandom_range(1));
    x.exc = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
    if (!x.bubble && $urandom_range(1) == 1) begin
      x.ld = 1'b1; x.opcode = 5'($urandom_range(11, 3));
    end else begin
      x.opcode = 5'($urandom_range(31, 12)); x.st = ($urandom_range(3) == 0);
    end
    return x;
  endfunction

  task automatic drive(input instr_t x);
    bubble_in = x.bubble; opcode_in = x.opcode; tgt_in_1 = x.tgt1; tgt_in_2 = x.tgt2;
    result_in_1 = x.r1; result_in_2 = x.r2; addr_in = x.addr; pc_in = x.pc;
    is_load_in = x.ld; is_store_in = x.st; tgts_cr_in = x.cr; exc_in = x.exc;
  endtask

  // One cycle: apply memory response, check the combinational stall, clock.
  task automatic step(input logic rdy, input logic [31:0] rd, input logic exp_stall,
                      input string tag);
    mem_ready = rdy; mem_rdata = rd;
    #1;
    chk({tag, ".stall"}, mem_stall, exp_stall);
    @(posedge clk); #1;
  endtask

  task automatic chk_wb_bubble(input string tag);
    chk({tag, ".wbb"},  wb_bubble, 1);
    chk({tag, ".wbt1"}, wb_tgt_1, 0);
    chk({tag, ".wbt2"}, wb_tgt_2, 0);
    chk({tag, ".wbe"},  wb_exc, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mt1"}, mem_tgt_1, 0);        chk({tag, ".mt2"}, mem_tgt_2, 0);
    chk({tag, ".mr1"}, mem_result_out_1, 0); chk({tag, ".mr2"}, mem_result_out_2, 0);
    chk({tag, ".mb"},  mem_bubble, 1);       chk({tag, ".mld"}, is_load_mem, 0);
    chk({tag, ".mcr"}, mem_tgts_cr, 0);      chk({tag, ".mop"}, mem_opcode_out, 0);
    chk({tag, ".stl"}, mem_stall, 0);
    chk({tag, ".wr1"}, wb_result_out_1, 0);  chk({tag, ".wr2"}, wb_result_out_2, 0);
    chk({tag, ".wcr"}, wb_tgts_cr, 0);       chk({tag, ".wpc"}, wb_pc, 0);
    chk_wb_bubble(tag);
  endtask

  // With x held in MEM: expect min(d,TMO) stall cycles for a valid load,
  // then completion (faulting when d reaches TMO).
  task automatic run_instr(input string tag, input instr_t x, input int d, input logic [31:0] rd);
    bit vl, fault;
    int n;
    logic [31:0] r1;
    vl    = x.ld && !x.bubble && x.exc == 8'h00;
    n     = vl ? ((d < TMO) ? d : TMO) : 0;
    fault = vl && d >= TMO;
    chk({tag, ".mt1"}, mem_tgt_1, x.tgt1);        chk({tag, ".mt2"}, mem_tgt_2, x.tgt2);
    chk({tag, ".mr1"}, mem_result_out_1, x.r1);   chk({tag, ".mr2"}, mem_result_out_2, x.r2);
    chk({tag, ".mb"},  mem_bubble, x.bubble);     chk({tag, ".mld"}, is_load_mem, x.ld);
    chk({tag, ".mop"}, mem_opcode_out, x.opcode); chk({tag, ".mcr"}, mem_tgts_cr, x.cr);
    for (int k = 0; k < n; k++) begin
      step(1'b0, $urandom, 1'b1, tag);
      chk_wb_bubble(tag);
    end
    step(vl ? !fault : 1'($urandom_range(1)), rd, 1'b0, tag);
    r1 = x.ld ? extract(x.opcode, x.addr, rd) : x.r1;
    chk({tag, ".wbb"}, wb_bubble, x.bubble);
    chk({tag, ".wt1"}, wb_tgt_1, fault ? 5'd0 : x.tgt1);
    chk({tag, ".wt2"}, wb_tgt_2, fault ? 5'd0 : x.tgt2);
    chk({tag, ".wr1"}, wb_result_out_1, fault ? 32'd0 : r1);
    chk({tag, ".wr2"}, wb_result_out_2, x.r2);
    chk({tag, ".wex"}, wb_exc, fault ? BEXC : x.exc);
    chk({tag, ".wcr"}, wb_tgts_cr, x.cr);
    chk({tag, ".wpc"}, wb_pc, x.pc);
  endtask

  instr_t a, b, c, d, e, g, l1, l2, l3, l4, l5, l6, l7, l8, cur, nxt;

  initial begin
    rst = 1'b1; halt = 1'b0; clk_en = 1'b1; exc_in_wb = 1'b0; rfe_in_wb = 1'b0;
    mem_ready = 1'b1; mem_rdata = '0; drive(nop_i());
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("reset");

    // ALU op flows MEM then WB
    a = alu(5'd3, 32'h1234); drive(a);
    step(1'b1, 32'h0, 1'b0, "alu.cap");
    chk("alu.mem_tgt", mem_tgt_1, 3);
    l1 = ld(5'd9, 32'h102, 5'd5); drive(l1);
    run_instr("alu", a, 0, 32'h0);
    chk("alu.lit_t", wb_tgt_1, 3); chk("alu.lit_r", wb_result_out_1, 32'h1234);
    chk("alu.lit_b", wb_bubble, 0);

    // clk_en low freezes everything even with a load waiting on memory
    clk_en = 1'b0; drive(alu(5'd30, 32'h9999));
    step(1'b0, 32'h0, 1'b1, "frz");
    chk("frz.mt1", mem_tgt_1, 5); chk("frz.mop", mem_opcode_out, 9);
    chk("frz.wt1", wb_tgt_1, 3);  chk("frz.wr1", wb_result_out_1, 32'h1234);
    clk_en = 1'b1; drive(l1);

    // Sub-word loads
    l2 = ld(5'd6, 32'h102, 5'd6); drive(l2);
    run_instr("ldb", l1, 0, 32'hAABBCCDD); chk("ldb.lit", wb_result_out_1, 32'h000000BB);
    l3 = ld(5'd3, 32'h100, 5'd7); drive(l3);
    run_instr("ldd", l2, 0, 32'hAABBCCDD); chk("ldd.lit", wb_result_out_1, 32'h0000AABB);
    b = alu(5'd8, 32'h77); drive(b);
    run_instr("ldw", l3, 0, 32'hAABBCCDD); chk("ldw.lit", wb_result_out_1, 32'hAABBCCDD);

    // Three wait cycles, following ALU op neither lost nor duplicated
    l4 = ld(5'd4, 32'h204, 5'd9); drive(l4);
    run_instr("aluB", b, 0, 32'h0);
    c = alu(5'd10, 32'hC0FFEE); drive(c);
    run_instr("wait", l4, 3, 32'h13572468);
    drive(nop_i());
    run_instr("aluC", c, 0, 32'h0);
    chk("aluC.lit", wb_tgt_1, 10);

    // Timeout
    l5 = ld(5'd10, 32'h301, 5'd11); drive(l5);
    run_instr("nop1", nop_i(), 0, 32'h0);
    d = alu(5'd12, 32'hD00D); drive(d);
    run_instr("tmo", l5, 10, $urandom);
    chk("tmo.lit_e", wb_exc, BEXC); chk("tmo.lit_t", wb_tgt_1, 0);
    l6 = ld(5'd5, 32'h400, 5'd13); drive(l6);
    run_instr("aluD", d, 0, 32'h0);

    // Flush during WAIT
    e = alu(5'd14, 32'hE0E0); drive(e);
    step(1'b0, 32'h0, 1'b1, "fl.s1"); chk_wb_bubble("fl.s1");
    step(1'b0, 32'h0, 1'b1, "fl.s2"); chk_wb_bubble("fl.s2");
    exc_in_wb = 1'b1;
    step(1'b0, 32'h0, 1'b0, "fl.s3");
    exc_in_wb = 1'b0;
    chk("fl.mb", mem_bubble, 1); chk("fl.mt1", mem_tgt_1, 0); chk_wb_bubble("fl.wb");
    run_instr("fl.after", nop_i(), 0, 32'hDEADDEAD);
    l7 = ld(5'd3, 32'h500, 5'd15); drive(l7);
    run_instr("aluE", e, 0, 32'h0);

    // Reset mid-WAIT, then a load with normal latency
    drive(nop_i());
    step(1'b0, 32'h0, 1'b1, "rw.s1");
    step(1'b0, 32'h0, 1'b1, "rw.s2");
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; mem_ready = 1'b0;
    chk_reset("rstw");
    l8 = ld(5'd11, 32'h603, 5'd17); drive(l8);
    step(1'b1, 32'h0, 1'b0, "rl.cap");
    drive(nop_i());
    run_instr("rl", l8, 0, 32'h89ABCDEF); chk("rl.lit", wb_result_out_1, 32'h89);

    // Halt captures pc_in into wb_pc only
    g = alu(5'd20, 32'h1); g.pc = 32'hDEADBEE0; drive(g);
    halt = 1'b1; @(posedge clk); #1; halt = 1'b0;
    chk("halt.pc", wb_pc, 32'hDEADBEE0); chk("halt.mb", mem_bubble, 1);
    chk("halt.mt1", mem_tgt_1, 0); chk("halt.wbb", wb_bubble, 1);
    cur = nop_i(); cur.pc = '0;

    // Random instruction stream with random memory latency
    nxt = rnd_instr(); drive(nxt);
    for (int i = 0; i < 200; i++) begin
      run_instr("rnd", cur, int'($urandom_range(6)), $urandom);
      cur = nxt; nxt = rnd_instr(); drive(nxt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
